// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI APB sequencer: FSM state codes, SPI core
// register byte offsets and CTRL bit positions, plus the CTRL word builder.
package spi_seq_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WR_DIV    = 4'd1;
  localparam logic [3:0] ST_WR_SS     = 4'd2;
  localparam logic [3:0] ST_WR_TX     = 4'd3;
  localparam logic [3:0] ST_WR_CTRL   = 4'd4;
  localparam logic [3:0] ST_WAIT_DONE = 4'd5;
  localparam logic [3:0] ST_RD_RX     = 4'd6;
  localparam logic [3:0] ST_RESP      = 4'd7;
  localparam logic [3:0] ST_HALT      = 4'd8;

  localparam logic [4:0] ADDR_TXRX = 5'h00;
  localparam logic [4:0] ADDR_CTRL = 5'h10;
  localparam logic [4:0] ADDR_DIV  = 5'h14;
  localparam logic [4:0] ADDR_SS   = 5'h18;

  localparam int CTRL_GO     = 8;
  localparam int CTRL_RX_NEG = 9;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_LSB    = 11;
  localparam int CTRL_IE     = 12;
  localparam int CTRL_ASS    = 13;

  // mode is {lsb, tx_negedge, rx_negedge}; reserved bits stay zero
  function automatic logic [31:0] ctrl_word(input logic [6:0] len,
                                            input logic [2:0] mode,
                                            input logic ie);
    logic [31:0] w;
    w = '0;
    w[6:0]        = len;
    w[CTRL_GO]     = 1'b1;
    w[CTRL_RX_NEG] = mode[0];
    w[CTRL_TX_NEG] = mode[1];
    w[CTRL_LSB]    = mode[2];
    w[CTRL_IE]     = ie;
    w[CTRL_ASS]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/spi_apb_master_if.sv
// Single-access APB master engine: a req in idle launches SETUP, then ACCESS
// is held until pready. done pulses on the completing cycle, when rdata and
// err are valid (they are the live bus inputs).
module spi_apb_master_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        write,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [4:0]  paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  assign done  = psel & penable & pready;
  assign rdata = prdata;
  assign err   = pslverr;

  // SETUP/ACCESS sequencing; address/data/direction held for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (req && (!psel || done)) begin
      paddr   <= addr;
      pwdata  <= wdata;
      pwrite  <= write;
      psel    <= 1'b1;
      penable <= 1'b0;
    end else if (done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_apb_sequencer.sv
// Command-to-SPI-transfer sequencer: one cmd handshake becomes a DIVIDER
// (only when changed), SS, TX0 and CTRL write, a completion wait and an RX0
// read, returned on the rsp channel. A watchdog in the wait freezes the block.
// Build option SPI_SEQ_POLL_EN: completion is found by polling CTRL.GO
// instead of using IRQ, and CTRL is written with IE cleared.
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter int SS_NB     = 8,
  parameter int DIV_LEN   = 16,
  parameter int TIMEOUT_W = 20
`ifdef SPI_SEQ_POLL_EN
  , parameter int POLL_GAP = 4
`endif
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_tx,
  input  logic [6:0]         cmd_len,
  input  logic [2:0]         cmd_mode,
  input  logic [SS_NB-1:0]   cmd_ss,
  input  logic [DIV_LEN-1:0] cfg_divider,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               halted,
  output logic [4:0]         PADDR,
  output logic [31:0]        PWDATA,
  output logic               PWRITE,
  output logic               PSEL,
  output logic               PENABLE,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR,
  input  logic               IRQ
);

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WDOG_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
`ifdef SPI_SEQ_POLL_EN
  localparam logic       IE_BIT   = 1'b0;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP);
  logic [7:0] gap;
`else
  localparam logic       IE_BIT   = 1'b1;
`endif

  logic [3:0]           state;
  logic                 armed;
  logic                 issued;
  logic                 err_acc;
  logic                 div_valid;
  logic [DIV_LEN-1:0]   div_cache;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 wdog_fire;
  logic                 accept;
  logic                 div_change;

  logic [31:0]          tx_q;
  logic [6:0]           len_q;
  logic [2:0]           mode_q;
  logic [SS_NB-1:0]     ss_q;
  logic [DIV_LEN-1:0]   div_q;

  logic                 req;
  logic [4:0]           addr;
  logic [31:0]          wdata;
  logic                 write;
  logic                 done;
  logic [31:0]          rdata;
  logic                 err;

  assign cmd_ready  = armed & (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign halted     = (state == ST_HALT);
  assign rsp_err    = err_acc;
  assign accept     = cmd_valid & cmd_ready;
  assign div_change = !div_valid || (cfg_divider != div_cache);
  assign wdog_fire  = (wdog >= WDOG_FIRE);

  // One request per register state, raised only until the engine takes it
  always_comb begin
    req   = 1'b0;
    addr  = ADDR_TXRX;
    wdata = '0;
    write = 1'b0;
    case (state)
      ST_WR_DIV: begin
        addr                = ADDR_DIV;
        wdata[DIV_LEN-1:0]  = div_q;
        write               = 1'b1;
        req                 = !issued;
      end
      ST_WR_SS: begin
        addr              = ADDR_SS;
        wdata[SS_NB-1:0]  = ss_q;
        write             = 1'b1;
        req               = !issued;
      end
      ST_WR_TX: begin
        addr  = ADDR_TXRX;
        wdata = tx_q;
        write = 1'b1;
        req   = !issued;
      end
      ST_WR_CTRL: begin
        addr  = ADDR_CTRL;
        wdata = ctrl_word(len_q, mode_q, IE_BIT);
        write = 1'b1;
        req   = !issued;
      end
`ifdef SPI_SEQ_POLL_EN
      ST_WAIT_DONE: begin
        addr = ADDR_CTRL;
        req  = !issued && (gap == GAP_LAST) && !wdog_fire;
      end
`endif
      ST_RD_RX: begin
        addr = ADDR_TXRX;
        req  = !issued;
      end
      default: ;
    endcase
  end

  // Sequencer FSM, divider cache, watchdog and response capture
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      issued    <= 1'b0;
      err_acc   <= 1'b0;
      div_valid <= 1'b0;
      div_cache <= '0;
      wdog      <= '0;
      rsp_data  <= '0;
`ifdef SPI_SEQ_POLL_EN
      gap       <= '0;
`endif
    end else begin
      armed <= 1'b1;
      if (req)       issued <= 1'b1;
      else if (done) issued <= 1'b0;
      if (done) err_acc <= err_acc | err;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_acc <= 1'b0;
            state   <= div_change ? ST_WR_DIV : ST_WR_SS;
          end
        end
        ST_WR_DIV: begin
          if (done) begin
            div_cache <= div_q;
            div_valid <= 1'b1;
            state     <= ST_WR_SS;
          end
        end
        ST_WR_SS:   if (done) state <= ST_WR_TX;
        ST_WR_TX:   if (done) state <= ST_WR_CTRL;
        ST_WR_CTRL: begin
          if (done) begin
            state <= ST_WAIT_DONE;
            wdog  <= '0;
`ifdef SPI_SEQ_POLL_EN
            gap   <= '0;
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (wdog != WDOG_MAX) wdog <= wdog + 1'b1;
`ifdef SPI_SEQ_POLL_EN
          if (done) begin
            gap <= '0;
            if (!rdata[CTRL_GO]) state <= ST_RD_RX;
          end else if (!issued && wdog_fire) begin
            state <= ST_HALT;
          end else if (!issued && gap != GAP_LAST) begin
            gap <= gap + 8'd1;
          end
`else
          if (IRQ)            state <= ST_RD_RX;
          else if (wdog_fire) state <= ST_HALT;
`endif
        end
        ST_RD_RX: begin
          if (done) begin
            rsp_data <= rdata;
            state    <= ST_RESP;
          end
        end
        ST_RESP:  if (rsp_ready) state <= ST_IDLE;
        ST_HALT:  ;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Command fields captured at accept
  always_ff @(posedge PCLK) begin
    if (accept) begin
      tx_q   <= cmd_tx;
      len_q  <= cmd_len;
      mode_q <= cmd_mode;
      ss_q   <= cmd_ss;
      div_q  <= cfg_divider;
    end
  end

  spi_apb_master_if u_apb (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
    .write   (write),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .pwrite  (PWRITE),
    .psel    (PSEL),
    .penable (PENABLE),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

endmodule
